// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame transmitter: state encoding,
// default frame constants and the checksum helper.
package uart_frame_pkg;

    // First byte of every frame; the host-side decoder tests use the same value.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Default width of the frame length field.
    localparam int LEN_W_DEFAULT = 8;

    // State encoding for the framing FSM.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_LEN  = 3'd2;
    localparam logic [2:0] ST_PAY  = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        SYNC = ST_SYNC,
        LEN  = ST_LEN,
        PAY  = ST_PAY,
        CSUM = ST_CSUM
    } frame_state_t;

    // Byte that brings the running sum (LEN + payload) to zero mod 256.
    function automatic logic [7:0] csum_byte(input logic [7:0] acc);
        return (~acc) + 8'd1;
    endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// Frames a byte stream into SYNC, LEN, payload, CSUM packets and writes them
// into the UART transmit FIFO. Payload bytes pass straight from the source to
// the FIFO on the same cycle; nothing is buffered internally.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         LEN_W     = LEN_W_DEFAULT
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             tx_full,
    output logic             write_uart,
    output logic [7:0]       write_data,
    output logic             busy,
    output logic             done
);

    frame_state_t     state_reg, state_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] count_reg, count_next;
    logic [7:0]       csum_reg, csum_next;
    logic             done_reg, done_next;

    // Length as it appears on the wire and in the checksum (8-bit field).
    logic [7:0]       len_byte;
    assign len_byte = 8'(len_reg);

    // State and datapath registers; an asynchronous reset abandons any frame.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            len_reg   <= '0;
            count_reg <= '0;
            csum_reg  <= 8'h00;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            count_reg <= count_next;
            csum_reg  <= csum_next;
            done_reg  <= done_next;
        end
    end

    // Next-state, write strobe and datapath updates; a state only advances
    // on a cycle that actually writes into the FIFO.
    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        count_next = count_reg;
        csum_next  = csum_reg;
        done_next  = 1'b0;
        write_uart = 1'b0;
        write_data = 8'h00;
        s_ready    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    len_next   = frame_len;
                    count_next = '0;
                    csum_next  = 8'h00;
                    state_next = SYNC;
                end
            end

            SYNC: begin
                write_data = SYNC_BYTE;
                if (!tx_full) begin
                    write_uart = 1'b1;
                    state_next = LEN;
                end
            end

            LEN: begin
                write_data = len_byte;
                if (!tx_full) begin
                    write_uart = 1'b1;
                    csum_next  = csum_reg + len_byte;
                    state_next = (len_reg != '0) ? PAY : CSUM;
                end
            end

            PAY: begin
                // The source byte is consumed on exactly the cycle it is written.
                s_ready    = !tx_full;
                write_data = s_data;
                if (s_valid && !tx_full) begin
                    write_uart = 1'b1;
                    csum_next  = csum_reg + s_data;
                    count_next = count_reg + LEN_W'(1);
                    // len is nonzero here, so len-1 cannot underflow.
                    if (count_reg == len_reg - LEN_W'(1)) begin
                        state_next = CSUM;
                    end
                end
            end

            CSUM: begin
                write_data = csum_byte(csum_reg);
                if (!tx_full) begin
                    write_uart = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Keep the FIFO and source handshakes quiet while reset is asserted.
        if (reset) begin
            write_uart = 1'b0;
            s_ready    = 1'b0;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Randomized self-checking bench for uart_frame_tx. Each frame's expected
// byte sequence is built from the frame rules (SYNC, LEN, payload, negated
// sum) and compared with what the DUT writes, under varied stalls.
module tb_uart_frame_tx;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] frame_len;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       tx_full;
    logic       write_uart;
    logic [7:0] write_data;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] pl_tbl [256];

    uart_frame_tx dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .start      (start),
        .frame_len  (frame_len),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .tx_full    (tx_full),
        .write_uart (write_uart),
        .write_data (write_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one frame of length len using payload pl_tbl[0..len-1].
    // vmode: 0 s_valid always 1, 1 pattern 1,0,0, 2 random.
    // fmode: 0 never full, 1 random full, 2 full for 5 cycles after LEN write.
    // start_at: re-pulse start once this many bytes are written (-1 = never).
    // abort_at: assert reset once this many bytes are written (-1 = never).
    task automatic run_frame(input int len, input int vmode, input int fmode,
                             input int start_at, input int abort_at, input string name);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        logic [7:0] src_q[$];
        int sum = len;
        int first_w = -1;
        int last_w = -1;
        int done_n = 0;
        int done_cyc = -1;
        int viol = 0;
        int sready_len0 = 0;
        int full_left = 0;
        int hold_started = 0;
        int budget = len * 6 + 60;
        int nmin;
        bit fin = 1'b0;

        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(pl_tbl[i]);
            src_q.push_back(pl_tbl[i]);
            sum += pl_tbl[i];
        end
        exp_q.push_back(8'((256 - (sum % 256)) % 256));

        @(posedge clk_100MHz); #1;
        start     = 1'b1;
        frame_len = 8'(len);
        s_valid   = 1'b0;
        tx_full   = 1'b0;

        for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
            @(posedge clk_100MHz); #1;
            start     = (start_at >= 0 && got_q.size() == start_at) ? 1'b1 : 1'b0;
            frame_len = 8'($urandom_range(1, 255));
            case (vmode)
                0:       s_valid = 1'b1;
                1:       s_valid = (cyc % 3 == 1);
                default: s_valid = ($urandom_range(0, 3) != 0);
            endcase
            case (fmode)
                0: tx_full = 1'b0;
                1: tx_full = ($urandom_range(0, 3) == 0);
                default: begin
                    if (hold_started == 0 && got_q.size() == 2) begin
                        hold_started = 1;
                        full_left = 5;
                    end
                    tx_full = (full_left > 0);
                    if (full_left > 0) full_left--;
                end
            endcase
            s_data = (src_q.size() > 0) ? src_q[0] : 8'($urandom);

            #4;
            if (tx_full && (write_uart || s_ready)) viol++;
            if (len == 0 && s_ready) sready_len0++;
            if (write_uart) begin
                if (first_w < 0) first_w = cyc;
                last_w = cyc;
                got_q.push_back(write_data);
            end
            if (s_valid && s_ready && src_q.size() > 0) void'(src_q.pop_front());
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end

            if (abort_at >= 0 && got_q.size() == abort_at) begin
                reset = 1'b1;
                #1;
                check({name, "/rst_wr"}, int'(write_uart), 0);
                check({name, "/rst_busy"}, int'(busy), 0);
                check({name, "/rst_srdy"}, int'(s_ready), 0);
                repeat (2) begin
                    @(negedge clk_100MHz);
                    if (done) done_n++;
                    if (write_uart) viol++;
                end
                check({name, "/rst_done"}, done_n, 0);
                check({name, "/rst_viol"}, viol, 0);
                @(posedge clk_100MHz); #1;
                reset = 1'b0;
                check({name, "/rst_idle"}, int'(busy), 0);
                return;
            end

            if (done_cyc >= 0 && cyc >= done_cyc + 6) fin = 1'b1;
        end
        start = 1'b0;

        if (!fin) check({name, "/timeout"}, 0, 1);
        check({name, "/nbytes"}, got_q.size(), exp_q.size());
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            check($sformatf("%s/byte%0d", name, i), int'(got_q[i]), int'(exp_q[i]));
        end
        check({name, "/done_n"}, done_n, 1);
        check({name, "/done_lat"}, done_cyc, last_w + 1);
        check({name, "/full_viol"}, viol, 0);
        check({name, "/srdy_len0"}, sready_len0, 0);
        check({name, "/busy_end"}, int'(busy), 0);
        if (vmode == 0 && fmode == 0) begin
            check({name, "/first_w"}, first_w, 1);
            check({name, "/span"}, last_w - first_w, len + 2);
        end
        $display("frame %s len=%0d bytes=%0d done=%0d", name, len, got_q.size(), done_n);
    endtask

    initial begin
        int len;
        reset     = 1'b1;
        start     = 1'b0;
        frame_len = 8'h00;
        s_data    = 8'h00;
        s_valid   = 1'b0;
        tx_full   = 1'b0;
        repeat (3) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        check("reset/busy", int'(busy), 0);
        check("reset/done", int'(done), 0);
        check("reset/wr", int'(write_uart), 0);
        check("reset/srdy", int'(s_ready), 0);
        @(posedge clk_100MHz); #1;
        reset = 1'b0;

        // Directed: 01 02 03 gives A5 03 01 02 03 F7 back to back.
        pl_tbl[0] = 8'h01; pl_tbl[1] = 8'h02; pl_tbl[2] = 8'h03;
        run_frame(3, 0, 0, -1, -1, "t1");

        // Empty frame: A5 00 00, source never sees s_ready.
        run_frame(0, 0, 0, -1, -1, "t2");

        // FIFO full for 5 cycles after LEN; accumulator ends at 01 so the
        // transmitted checksum byte is FF.
        pl_tbl[0] = 8'hAA; pl_tbl[1] = 8'h55;
        run_frame(2, 0, 2, -1, -1, "t3");

        // Source valid only every third cycle.
        for (int i = 0; i < 4; i++) pl_tbl[i] = 8'($urandom);
        run_frame(4, 1, 0, -1, -1, "t4");

        // start re-pulsed during PAY must be ignored.
        for (int i = 0; i < 2; i++) pl_tbl[i] = 8'($urandom);
        run_frame(2, 0, 0, 3, -1, "t5");

        // Reset mid-PAY, then a clean 7F frame: A5 01 7F 80.
        for (int i = 0; i < 5; i++) pl_tbl[i] = 8'($urandom);
        run_frame(5, 0, 0, -1, 4, "t6a");
        pl_tbl[0] = 8'h7F;
        run_frame(1, 0, 0, -1, -1, "t6b");

        // Randomized frames with random source gaps and FIFO back-pressure.
        for (int k = 0; k < 10; k++) begin
            len = $urandom_range(0, 12);
            for (int i = 0; i < len; i++) pl_tbl[i] = 8'($urandom);
            run_frame(len, 2, 1, -1, -1, $sformatf("r%0d", k));
        end

        // Longest frame the length field allows.
        for (int i = 0; i < 255; i++) pl_tbl[i] = 8'($urandom);
        run_frame(255, 0, 1, -1, -1, "max");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
